// File: rtl/seg7_to_num.sv
// seg7_to_num: stability-filtered 7-segment pattern decoder with a one-entry
// valid/ready holding register and sticky overrun flag.
module seg7_to_num #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_n,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_digit,
    output logic       out_blank,
    output logic       out_err,
    output logic       overrun
);
    localparam logic [7:0] S = 8'(STABLE_CYCLES);
    logic [6:0] seg_q, cand, last;
    logic       last_ok;
    logic [7:0] cnt;
    logic       changed, accept, emit;
    logic [3:0] dec_digit;
    logic       dec_blank, dec_err;
    // cand is always the previous seg_q, so a mismatch marks the start of a new run
    always_comb begin
        changed = seg_q != cand;
        accept  = changed ? (S == 8'd1) : (cnt == S - 8'd1);
        emit    = accept && (!last_ok || seg_q != last);
    end
    always_comb begin
        dec_digit = 4'h0;
        dec_blank = seg_q == 7'h00;
        dec_err   = 1'b0;
        case (seg_q)
            7'h7E: dec_digit = 4'h0;
            7'h30: dec_digit = 4'h1;
            7'h6D: dec_digit = 4'h2;
            7'h79: dec_digit = 4'h3;
            7'h33: dec_digit = 4'h4;
            7'h5B: dec_digit = 4'h5;
            7'h5F: dec_digit = 4'h6;
            7'h70: dec_digit = 4'h7;
            7'h7F: dec_digit = 4'h8;
            7'h7B: dec_digit = 4'h9;
            7'h77: dec_digit = 4'hA;
            7'h1F: dec_digit = 4'hB;
            7'h4E: dec_digit = 4'hC;
            7'h3D: dec_digit = 4'hD;
            7'h4F: dec_digit = 4'hE;
            7'h47: dec_digit = 4'hF;
            7'h00: dec_digit = 4'h0;
            default: dec_err = 1'b1;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q     <= 7'h00;
            cand      <= 7'h00;
            cnt       <= 8'd0;
            last      <= 7'h00;
            last_ok   <= 1'b0;
            out_valid <= 1'b0;
            out_digit <= 4'h0;
            out_blank <= 1'b0;
            out_err   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            seg_q <= ~seg_n;
            cand  <= seg_q;
            cnt   <= changed ? 8'd1 : (cnt == S ? cnt : cnt + 8'd1);
            if (emit) begin
                last      <= seg_q;
                last_ok   <= 1'b1;
                out_valid <= 1'b1;
                out_digit <= dec_digit;
                out_blank <= dec_blank;
                out_err   <= dec_err;
                if (out_valid && !out_ready)
                    overrun <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seg7_to_num.sv
// tb_seg7_to_num: directed and randomized checks of seg7_to_num against a
// run-length reference model.
module tb_seg7_to_num;
    localparam int S = 4;
    localparam logic [6:0] GLYPH [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                          7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    logic       clk = 1'b0, rst = 1'b1, out_ready = 1'b0;
    logic [6:0] seg_n = 7'h7F;
    logic       out_valid, out_blank, out_err, overrun;
    logic [3:0] out_digit;
    int n_checks = 0, n_fail = 0;
    logic [6:0] m_segq = 7'h00, m_last = 7'h00;
    int         m_run = 1;
    logic       m_last_ok = 1'b0, m_valid = 1'b0, m_ovr = 1'b0;
    logic [5:0] m_pay = 6'h00;
    logic [5:0] dut_log [$];
    int         first;

    seg7_to_num #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .seg_n(seg_n), .out_ready(out_ready),
        .out_valid(out_valid), .out_digit(out_digit), .out_blank(out_blank),
        .out_err(out_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] decode(logic [6:0] v);
        for (int i = 0; i < 16; i++)
            if (GLYPH[i] == v) return {2'b00, 4'(i)};
        return (v == 7'h00) ? 6'b010000 : 6'b100000;
    endfunction

    // A pattern is accepted on the edge where its run of sampled copies reaches S
    task automatic step();
        logic [6:0] nq;
        if (rst) begin
            m_segq = 7'h00; m_run = 1; m_last_ok = 1'b0; m_last = 7'h00;
            m_valid = 1'b0; m_pay = 6'h00; m_ovr = 1'b0;
        end else begin
            if (m_run == S && (!m_last_ok || m_segq != m_last)) begin
                if (m_valid && !out_ready) m_ovr = 1'b1;
                m_valid = 1'b1; m_pay = decode(m_segq); m_last = m_segq; m_last_ok = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            nq = ~seg_n;
            m_run = (nq == m_segq) ? m_run + 1 : 1;
            m_segq = nq;
        end
        @(posedge clk);
        #1;
        check("valid", out_valid, m_valid);
        check("overrun", overrun, m_ovr);
        if (m_valid) check("payload", {out_err, out_blank, out_digit}, m_pay);
        if (out_valid) dut_log.push_back({out_err, out_blank, out_digit});
    endtask

    task automatic hold(logic [6:0] s, int n);
        seg_n = s;
        repeat (n) step();
    endtask

    initial begin
        rst = 1'b1; seg_n = 7'h24;
        repeat (2) step();
        check("rst_outs", {out_valid, out_digit, out_blank, out_err, overrun}, 0);
        rst = 1'b0; out_ready = 1'b1; first = 0;
        dut_log.delete();
        for (int i = 1; i <= 8; i++) begin
            step();
            if (out_valid && first == 0) first = i;
        end
        check("rst_latency", first, S + 1);
        check("rst_emits", dut_log.size(), 1);
        check("rst_digit", dut_log.size() > 0 ? dut_log[0] : 6'h3F, 6'h05);

        dut_log.delete();
        for (int i = 0; i < 16; i++) hold(~GLYPH[i], 8);
        check("sweep_emits", dut_log.size(), 16);
        for (int i = 0; i < 16 && i < dut_log.size(); i++) check("sweep_digit", dut_log[i], i);
        check("sweep_ovr", overrun, 0);

        dut_log.delete();
        hold(7'h06, 8);
        hold(7'h4F, 3);
        hold(7'h06, 8);
        check("glitch3_emits", dut_log.size(), 1);
        hold(7'h4F, 4);
        hold(7'h06, 8);
        check("glitch4_emits", dut_log.size(), 3);
        if (dut_log.size() == 3) begin
            check("glitch4_first", dut_log[1], 6'h01);
            check("glitch4_back", dut_log[2], 6'h03);
        end

        dut_log.delete();
        hold(7'h7F, 6);
        check("blank", dut_log.size() > 0 ? dut_log[dut_log.size()-1] : 6'h3F, 6'b010000);
        dut_log.delete();
        hold(7'h7E, 6);
        check("invalid", dut_log.size() > 0 ? dut_log[dut_log.size()-1] : 6'h3F, 6'b100000);

        out_ready = 1'b0;
        hold(~GLYPH[2], 6);
        hold(~GLYPH[7], 6);
        check("bp_valid", out_valid, 1);
        check("bp_digit", out_digit, 7);
        check("bp_ovr", overrun, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_drain", out_valid, 0);
        repeat (3) step();
        check("bp_sticky", overrun, 1);

        out_ready = 1'b1;
        hold(~GLYPH[9], 2);
        rst = 1'b1;
        step();
        rst = 1'b0; first = 0;
        dut_log.delete();
        for (int i = 1; i <= 8; i++) begin
            step();
            if (out_valid && first == 0) first = i;
        end
        check("mid_latency", first, S + 1);
        check("mid_digit", dut_log.size() > 0 ? dut_log[0] : 6'h3F, 6'h09);
        check("mid_ovr", overrun, 0);

        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0: seg_n = $urandom_range(0, 127);
                1: seg_n = 7'h7F;
                default: seg_n = ~GLYPH[$urandom_range(0, 15)];
            endcase
            rst = ($urandom_range(0, 39) == 0);
            for (int j = $urandom_range(1, 8); j > 0; j--) begin
                out_ready = $urandom_range(0, 1) == 1;
                step();
                rst = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
